// File: rtl/fmem_port_if.sv
// ---------------------------------------------------------------------------
// fmem_port_if
//   Request/response bundle between a client and one fmem port controller.
//
//   Handshake rule for both channels: a transfer happens on a rising clk edge
//   where valid & ready are both 1; the producer holds valid and its payload
//   stable until that edge, and ready never depends on valid.
//
//   Signals
//     req_valid / req_ready   request handshake
//     req_we                  1 = write, 0 = read
//     req_addr  [ADDR_W]      word address
//     req_wdata [DATA_W]      write data (ignored for reads)
//     rsp_valid / rsp_ready   read-response handshake
//     rsp_rdata [DATA_W]      read data, in request order
//
//   Modports: master = client side, slave = controller side.
// ---------------------------------------------------------------------------
interface fmem_port_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/fmem_port_ctrl.sv
// ---------------------------------------------------------------------------
// fmem_port_ctrl
//   Initiator for one port of the dual-port frame memory (SRAM2RW16x32 banks).
//   In-order read/write requests are turned into registered active-low SRAM
//   controls; read data is captured into a first-word-fall-through response
//   FIFO. Read credits are reserved at accept time so returning data always
//   has a FIFO slot.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     bus (slave)         request / response handshake bundle
//     mem_CSB/WEB/OEB     SRAM chip select / write enable / output enable (low)
//     mem_A, mem_I        SRAM address and write data
//     mem_O               SRAM read data
//     busy                access stage, read stage or FIFO non-empty
//
//   Pipeline for a request accepted at the end of cycle n:
//     n+1 access stage (CSB=0), n+2 read stage (OEB=0, FIFO push at its end),
//     n+3 rsp_valid when the FIFO was empty.
// ---------------------------------------------------------------------------
module fmem_port_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 128,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    fmem_port_if.slave        bus,
    output logic              mem_CSB,
    output logic              mem_WEB,
    output logic              mem_OEB,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_I,
    input  logic [DATA_W-1:0] mem_O,
    output logic              busy
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic              csb_q;
    logic              web_q;
    logic              acc_rd;     // access stage holds a read
    logic              rd_stage;   // read stage: SRAM data is on mem_O
    logic [CW-1:0]     credits;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

    logic accept;
    logic rd_accept;
    logic push;
    logic pop;
    logic full;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign accept    = bus.req_valid & bus.req_ready;
    assign rd_accept = accept & ~bus.req_we;
    assign push      = rd_stage;
    assign pop       = bus.rsp_valid & bus.rsp_ready;
    assign full      = (fifo_count == DEPTH_C);

    // Credits cover every read from accept until its FIFO entry is popped,
    // so the FIFO can never be asked to take more than it holds.
    assign bus.req_ready = ~rst & (credits < DEPTH_C);
    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;

    // Reset gates the strobes combinationally so an access stage that
    // coincides with the reset cycle never reaches the SRAM edge.
    assign mem_CSB = csb_q | rst;
    assign mem_WEB = web_q | rst;
    assign mem_OEB = ~rd_stage | rst;

    assign busy = ~csb_q | rd_stage | bus.rsp_valid;

    // Access stage: one SRAM operation per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            csb_q  <= 1'b1;
            web_q  <= 1'b1;
            acc_rd <= 1'b0;
            mem_A  <= '0;
            mem_I  <= '0;
        end else if (accept) begin
            csb_q  <= 1'b0;
            web_q  <= ~bus.req_we;
            acc_rd <= ~bus.req_we;
            mem_A  <= bus.req_addr;
            if (bus.req_we) begin
                mem_I <= bus.req_wdata;
            end
        end else begin
            csb_q  <= 1'b1;
            web_q  <= 1'b1;
            acc_rd <= 1'b0;
        end
    end

    // Read stage follows a read access by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_stage <= 1'b0;
        end else begin
            rd_stage <= acc_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({rd_accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_O;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop));

    no_credit_overrun: assert property (@(posedge clk) disable iff (rst)
        credits <= DEPTH_C);
endmodule
